fetch_unit: RTL and testbench

Instruction fetch stage of the MIPS core: holds the PC, fetches instruction words from instruction memory over a ready handshake, presents the held instruction and its opcode to `control_unit`, and computes the next PC from the branch/jump controls that `control_unit` and the ALU return. One instruction is in flight at a time: fetch, hold until executed, redirect.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_unit_if.sv | 29 ++
 rtl/next_pc_logic.sv | 59 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - fetch_state_e : fetch FSM states (S_FAULT exists only when
//                     FETCH_ALIGN_CHECK_EN is defined)
//   - RESET_PC_DEFAULT, NOP
//   - bit positions of the opcode, immediate and jump-target fields
// Optional feature macro: FETCH_ALIGN_CHECK_EN
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_FAULT = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory port of the fetch stage.
//   imem_req   : fetch request (driven by the fetch unit)
//   imem_addr  : fetch address
//   imem_rdata : instruction word returned by memory
//   imem_ready : memory accepts the request and returns imem_rdata this cycle
// Handshake: a fetch completes in exactly the cycle where imem_req=1 and
// imem_ready=1 (rising clock edge at the end of that cycle). imem_addr is held
// stable while imem_req=1 and imem_ready=0. imem_ready carries no meaning
// while imem_req=0.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
//   instr_pc  : address of the held instruction
//   instr     : low 26 bits of the held instruction (imm / jump target fields)
//   beq, bne, j, jal, jr, zero : branch/jump controls and ALU zero flag
//   jr_target : register value used by jr
//   next_pc   : selected next PC (priority jr > j/jal > taken branch > +4)
//   pc_plus4  : instr_pc + 4 (also the jal link value)
// Optional feature macro: FETCH_ALIGN_CHECK_EN (when undefined, jr_target[1:0]
// is forced to zero here so the PC can never become misaligned).
module next_pc_logic
  import fetch_pkg::*;
(
  input  logic [31:0]         instr_pc,
  input  logic [TARGET_MSB:0] instr,
  input  logic                beq,
  input  logic                bne,
  input  logic                j,
  input  logic                jal,
  input  logic                jr,
  input  logic                zero,
  input  logic [31:0]         jr_target,
  output logic [31:0]         next_pc,
  output logic [31:0]         pc_plus4
);

  logic [31:0] jr_tgt_eff;
  logic [31:0] jump_tgt;
  logic [31:0] branch_tgt;
  logic [31:0] imm_sext;
  logic        branch_taken;

  always_comb begin
    pc_plus4 = instr_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    // Raw target is kept so the fetch unit can detect misalignment.
    jr_tgt_eff = jr_target;
`else
    jr_tgt_eff = jr_target & 32'hFFFF_FFFC;
`endif

    imm_sext     = {{16{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
    branch_tgt   = pc_plus4 + (imm_sext << 2);
    // Region bits come from pc_plus4, not instr_pc (matters at a 256MB edge).
    jump_tgt     = {pc_plus4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    branch_taken = (beq & zero) | (bne & ~zero);

    if (jr) begin
      next_pc = jr_tgt_eff;
    end else if (j | jal) begin
      next_pc = jump_tgt;
    end else if (branch_taken) begin
      next_pc = branch_tgt;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage, one instruction in flight at a time.
//   clk, reset   : clock, synchronous active-high reset
//   imem         : instruction memory port (fetch_unit_if.master)
//   instr        : held instruction;  opcode : instr[31:26]
//   instr_pc     : address of held instruction;  pc_plus4 : instr_pc + 4
//   instr_valid  : held instruction awaiting execution
//   instr_ack    : datapath completed the held instruction
//   stall        : suppresses instr_ack this cycle
//   beq, bne, j, jal, jr, zero, jr_target : next-PC controls
//   fault        : sticky misaligned-target fault
//   dbg_state    : current FSM state
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned next PC traps into
// S_FAULT until reset; when undefined fault is tied low).
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic [31:0]         instr,
  output logic [5:0]          opcode,
  output logic [31:0]         instr_pc,
  output logic [31:0]         pc_plus4,
  output logic                instr_valid,
  input  logic                instr_ack,
  input  logic                stall,
  input  logic                beq,
  input  logic                bne,
  input  logic                j,
  input  logic                jal,
  input  logic                jr,
  input  logic                zero,
  input  logic [31:0]         jr_target,
  output logic                fault,
  output fetch_state_e        dbg_state
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .instr_pc  (instr_pc_q),
    .instr     (instr_q[TARGET_MSB:0]),
    .beq       (beq),
    .bne       (bne),
    .j         (j),
    .jal       (jal),
    .jr        (jr),
    .zero      (zero),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .pc_plus4  (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    imem.imem_req = 1'b0;
    instr_valid   = 1'b0;

    case (state_q)
      S_FETCH: begin
        // Request is masked during reset so memory never sees a stale fetch.
        imem.imem_req = ~reset;
        if (imem.imem_ready) begin
          instr_d    = imem.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ack && !stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (next_pc[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc;
          state_d = S_FETCH;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign opcode         = instr_q[OPCODE_MSB:OPCODE_LSB];
  assign instr_pc       = instr_pc_q;
  assign dbg_state      = state_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = (state_q == S_FAULT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. The bench plays the
// instruction memory and the datapath; expected fetch addresses come from a
// behavioural next-PC model and are queued in exp_q.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if imem_if ();

  logic [31:0]  instr, instr_pc, pc_plus4, jr_target;
  logic [5:0]   opcode;
  logic         instr_valid, instr_ack, stall, fault;
  logic         beq, bne, j, jal, jr, zero;
  fetch_state_e dbg_state;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem_if),
    .instr       (instr),
    .opcode      (opcode),
    .instr_pc    (instr_pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .instr_ack   (instr_ack),
    .stall       (stall),
    .beq         (beq),
    .bne         (bne),
    .j           (j),
    .jal         (jal),
    .jr          (jr),
    .zero        (zero),
    .jr_target   (jr_target),
    .fault       (fault),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_pc;
  logic [31:0] cur_word;
  bit          faulted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Behavioural next-PC model written from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           input logic c_jr, input logic c_j, input logic c_jal,
                                           input logic c_beq, input logic c_bne, input logic z,
                                           input logic [31:0] jt);
    logic [31:0] p4;
    int          off;
    p4  = pc + 32'd4;
    off = $signed(w[15:0]);
    if (c_jr) begin
`ifdef FETCH_ALIGN_CHECK_EN
      return jt;
`else
      return jt - (jt % 4);
`endif
    end
    if (c_j || c_jal) return (p4 & 32'hF000_0000) + (w % 32'h0400_0000) * 4;
    if ((c_beq && z) || (c_bne && !z)) return p4 + 32'(off * 4);
    return p4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_ctl();
    {beq, bne, j, jal, jr, zero} = 6'($urandom);
    jr_target = $urandom;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = $urandom;
    instr_ack = 1'($urandom);
    stall = 1'b0;
    garbage_ctl();
    #1;
    chk("req_low_in_reset", {31'b0, imem_if.imem_req}, 32'd0);
    tick();
    chk("rst_req",      {31'b0, imem_if.imem_req}, 32'd0);
    chk("rst_instr",    instr, NOP);
    chk("rst_opcode",   {26'b0, opcode}, 32'd0);
    chk("rst_instr_pc", instr_pc, RST_PC);
    chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
    chk("rst_fault",    {31'b0, fault}, 32'd0);
    chk("rst_state",    {30'b0, dbg_state}, {30'b0, S_FETCH});
    reset = 1'b0;
    imem_if.imem_ready = 1'b0;
    instr_ack = 1'b0;
    #1;
    chk("req_after_reset", {31'b0, imem_if.imem_req}, 32'd1);
    chk("addr_after_reset", imem_if.imem_addr, RST_PC);
    exp_q.delete();
    exp_q.push_back(RST_PC);
  endtask

  // Fetch one word with 'waits' wait-state cycles; controls are garbage.
  task automatic fetch_instr(input logic [31:0] word, input int waits);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL exp_q_empty observed=0 expected=1");
      cur_pc = 32'hx;
    end else begin
      cur_pc = exp_q.pop_front();
    end
    cur_word = word;
    for (int i = 0; i < waits; i++) begin
      imem_if.imem_ready = 1'b0;
      imem_if.imem_rdata = $urandom;
      instr_ack = 1'($urandom);
      stall = 1'($urandom);
      garbage_ctl();
      #1;
      chk("wait_req",   {31'b0, imem_if.imem_req}, 32'd1);
      chk("wait_addr",  imem_if.imem_addr, cur_pc);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
      tick();
    end
    imem_if.imem_ready = 1'b1;
    imem_if.imem_rdata = word;
    instr_ack = 1'($urandom);
    garbage_ctl();
    #1;
    chk("fetch_req",  {31'b0, imem_if.imem_req}, 32'd1);
    chk("fetch_addr", imem_if.imem_addr, cur_pc);
    tick();
    imem_if.imem_ready = 1'($urandom);
    imem_if.imem_rdata = $urandom;
    #1;
    chk("hold_valid",    {31'b0, instr_valid}, 32'd1);
    chk("hold_req",      {31'b0, imem_if.imem_req}, 32'd0);
    chk("hold_instr",    instr, word);
    chk("hold_opcode",   {26'b0, opcode}, {26'b0, word[31:26]});
    chk("hold_instr_pc", instr_pc, cur_pc);
    chk("hold_pc_plus4", pc_plus4, cur_pc + 32'd4);
  endtask

  // Stall 'stalls' cycles, then accept with the given controls.
  task automatic execute(input logic c_jr, input logic c_j, input logic c_jal,
                         input logic c_beq, input logic c_bne, input logic z,
                         input logic [31:0] jt, input int stalls, output bit flt);
    logic [31:0] nxt;
    flt = 1'b0;
    for (int i = 0; i < stalls; i++) begin
      instr_ack = 1'b1;
      stall = 1'b1;
      imem_if.imem_ready = 1'($urandom);
      garbage_ctl();
      #1;
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, cur_word);
      chk("stall_pc",    imem_if.imem_addr, cur_pc);
      tick();
    end
    instr_ack = 1'b1;
    stall = 1'b0;
    {jr, j, jal, beq, bne, zero} = {c_jr, c_j, c_jal, c_beq, c_bne, z};
    jr_target = jt;
    nxt = ref_next(cur_pc, cur_word, c_jr, c_j, c_jal, c_beq, c_bne, z, jt);
    tick();
    instr_ack = 1'($urandom);
    imem_if.imem_ready = 1'b0;
    garbage_ctl();
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    if (nxt[1:0] != 2'b00) begin
      flt = 1'b1;
      for (int i = 0; i < 4; i++) begin
        imem_if.imem_ready = 1'($urandom);
        instr_ack = 1'($urandom);
        #1;
        chk("fault_flag",  {31'b0, fault}, 32'd1);
        chk("fault_req",   {31'b0, imem_if.imem_req}, 32'd0);
        chk("fault_valid", {31'b0, instr_valid}, 32'd0);
        tick();
      end
      return;
    end
`endif
    chk("next_valid", {31'b0, instr_valid}, 32'd0);
    chk("next_req",   {31'b0, imem_if.imem_req}, 32'd1);
    chk("next_addr",  imem_if.imem_addr, nxt);
    chk("next_fault", {31'b0, fault}, 32'd0);
    exp_q.push_back(nxt);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    imem_if.imem_ready = 1'b0;
    imem_if.imem_rdata = 32'h0;
    instr_ack = 1'b0;
    stall = 1'b0;
    {beq, bne, j, jal, jr, zero} = 6'b0;
    jr_target = 32'h0;
    tick();
    do_reset();

    // Sequential fetch: 0x0, 0x4, 0x8, then 0xC to reach 0x10.
    for (int i = 0; i < 4; i++) begin
      fetch_instr(NOP, 0);
      execute(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, faulted);
    end

    // beq taken at 0x10 -> 0x20, jr back, beq not taken -> 0x14.
    fetch_instr(32'h1000_0003, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 0, faulted);
    fetch_instr(NOP, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 0, faulted);
    fetch_instr(32'h1000_0003, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, faulted);

    // jal at 0x4000_0010 with target field 0x100.
    fetch_instr(NOP, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4000_0010, 0, faulted);
    fetch_instr(32'h0C00_0100, 0);
    chk("jal_link", pc_plus4, 32'h4000_0014);
    execute(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, faulted);

    // Priority: jr beats a taken beq.
    fetch_instr(32'h1000_0003, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 0, faulted);

    // Wrap: +4 from 0xFFFF_FFFC gives 0.
    fetch_instr(NOP, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0, faulted);
    fetch_instr(NOP, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, faulted);

    // Three wait states, two stall cycles, then reset mid-hold.
    fetch_instr(32'h2345_6789, 3);
    for (int i = 0; i < 2; i++) begin
      instr_ack = 1'b1;
      stall = 1'b1;
      garbage_ctl();
      #1;
      chk("mid_stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("mid_stall_pc",    imem_if.imem_addr, cur_pc);
      tick();
    end
    do_reset();

    // Randomized instructions, controls, wait states and stalls.
    for (int n = 0; n < 40; n++) begin
      logic        r_jr, r_j, r_jal, r_beq, r_bne, r_z;
      logic [31:0] r_jt;
      fetch_instr($urandom, $urandom_range(0, 2));
      r_jr  = ($urandom_range(0, 4) == 0);
      r_j   = ($urandom_range(0, 5) == 0);
      r_jal = ($urandom_range(0, 5) == 0);
      r_beq = ($urandom_range(0, 2) == 0);
      r_bne = ($urandom_range(0, 2) == 0);
      r_z   = 1'($urandom);
`ifdef FETCH_ALIGN_CHECK_EN
      r_jt  = $urandom & 32'hFFFF_FFFC;
`else
      r_jt  = $urandom;
`endif
      execute(r_jr, r_j, r_jal, r_beq, r_bne, r_z, r_jt, $urandom_range(0, 2), faulted);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    // Misaligned jr target.
    fetch_instr(NOP, 0);
    execute(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h202, 0, faulted);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("misalign_faulted", {31'b0, faulted}, 32'd1);
`else
    chk("misalign_faulted", {31'b0, faulted}, 32'd0);
`endif
    do_reset();
    fetch_instr(NOP, 0);
    execute(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1, faulted);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
